// File: rtl/overflow_safe_accumulator.sv
// Packet accumulator: sums unsigned beats until in_last, then holds the result until out_ready.
// Optional macro SATURATE_EN clamps the sum at all-ones on overflow; otherwise the sum wraps.
module overflow_safe_accumulator #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic [1:0]        state_out
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ACCUM = 2'b01;
  localparam logic [1:0] HOLD  = 2'b10;

  logic [1:0]       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ovf, ovf_nxt;
  logic             vld_q;
  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_add;

  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign accept   = in_valid && in_ready;

  // One extra bit so the carry-out of the add is visible.
  assign sum_ext = {1'b0, acc} + (ACC_W+1)'(in_data);
  assign carry   = sum_ext[ACC_W];

`ifdef SATURATE_EN
  assign acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_add = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = ACC_W'(in_data);
          count_nxt = CNT_W'(1);
          ovf_nxt   = 1'b0;
          state_nxt = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt   = acc_add;
          ovf_nxt   = ovf | carry;
          count_nxt = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
          if (in_last) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;  // illegal code: recover without touching data
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
      vld_q <= (state_nxt == HOLD);
    end
  end

  assign out_valid = vld_q;
  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;
  assign state_out = state;

endmodule

// File: tb/tb_overflow_safe_accumulator.sv
// Bench for overflow_safe_accumulator: directed packet table, corner sequences, random packets vs model.
module tb_overflow_safe_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [3:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_sum;
  logic [3:0] out_count;
  logic       out_ovf;
  logic [1:0] state_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  overflow_safe_accumulator #(.DATA_W(4), .ACC_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf), .state_out(state_out)
  );

  typedef struct {
    int n;
    int base;
    int step;
    int exp_sum;
    int exp_cnt;
    int exp_ovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a packet is its list of beats; results follow from the true sum.
  task automatic model(input int beats[$], output int s, output int c, output int o);
    int tot = 0;
    foreach (beats[i]) tot += beats[i];
    o = (tot > 255) ? 1 : 0;
`ifdef SATURATE_EN
    s = (tot > 255) ? 255 : tot;
`else
    s = tot % 256;
`endif
    c = (beats.size() > 15) ? 15 : beats.size();
  endtask

  // Drive beats at negedges, optionally with idle gaps carrying junk data.
  task automatic send(input int beats[$], input bit gaps);
    foreach (beats[i]) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0; in_data = 4'($urandom); in_last = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = 4'(beats[i]);
      in_last  = (i == beats.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic check_result(input string tag, input int s, input int c, input int o);
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " state"}, state_out, 2);
    chk({tag, " sum"}, out_sum, s);
    chk({tag, " count"}, out_count, c);
    chk({tag, " ovf"}, out_ovf, o);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " drained out_valid"}, out_valid, 0);
    chk({tag, " drained state"}, state_out, 0);
  endtask

  initial begin
    vec_t vecs[6];
    int   q[$];
    int   es, ec, eo;

    vecs[0] = '{n: 3,  base: 3,  step: 2, exp_sum: 15,  exp_cnt: 3,  exp_ovf: 0};
`ifdef SATURATE_EN
    vecs[1] = '{n: 20, base: 15, step: 0, exp_sum: 255, exp_cnt: 15, exp_ovf: 1};
`else
    vecs[1] = '{n: 20, base: 15, step: 0, exp_sum: 44,  exp_cnt: 15, exp_ovf: 1};
`endif
    vecs[2] = '{n: 1,  base: 9,  step: 0, exp_sum: 9,   exp_cnt: 1,  exp_ovf: 0};
    vecs[3] = '{n: 17, base: 15, step: 0, exp_sum: 255, exp_cnt: 15, exp_ovf: 0};
    vecs[4] = '{n: 18, base: 1,  step: 0, exp_sum: 18,  exp_cnt: 15, exp_ovf: 0};
    vecs[5] = '{n: 2,  base: 0,  step: 0, exp_sum: 0,   exp_cnt: 2,  exp_ovf: 0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset sum", out_sum, 0);
    chk("reset count", out_count, 0);
    chk("reset ovf", out_ovf, 0);
    chk("reset state", state_out, 0);
    chk("reset in_ready", in_ready, 1);

    // Directed table
    for (int v = 0; v < 6; v++) begin
      q.delete();
      for (int i = 0; i < vecs[v].n; i++) q.push_back((vecs[v].base + i * vecs[v].step) % 16);
      send(q, 1'b0);
      check_result($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cnt, vecs[v].exp_ovf);
      drain($sformatf("vec%0d", v));
    end

    // Result held under backpressure while the source keeps offering beats
    q = '{9};
    send(q, 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 4'($urandom); in_last = 1'($urandom);
      chk("hold in_ready", in_ready, 0);
      chk("hold sum", out_sum, 9);
      chk("hold count", out_count, 1);
      chk("hold out_valid", out_valid, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain("hold");

    // Reset mid-packet discards partial sum
    q = '{4, 6};
    foreach (q[i]) begin
      in_valid = 1'b1; in_data = 4'(q[i]); in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre-rst state", state_out, 1);
    rst = 1'b1;
    #1;
    chk("async rst state", state_out, 0);
    chk("async rst sum", out_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    q = '{2};
    send(q, 1'b0);
    check_result("after rst", 2, 1, 0);
    drain("after rst");

    // Reset while holding a result
    q = '{5, 5};
    send(q, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst in hold out_valid", out_valid, 0);
    chk("rst in hold in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Illegal state code recovers to IDLE without touching data
    q = '{7, 8};
    send(q, 1'b0);
    drain("pre-illegal");
    force dut.state = 2'b11;
    #1;
    release dut.state;
    @(negedge clk);
    chk("illegal state", state_out, 0);
    chk("illegal sum", out_sum, 15);
    chk("illegal count", out_count, 2);

    // Random packets against the model
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 24);
      q.delete();
      for (int i = 0; i < len; i++)
        q.push_back(($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 15));
      model(q, es, ec, eo);
      send(q, 1'b1);
      check_result($sformatf("rand%0d", p), es, ec, eo);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drain($sformatf("rand%0d", p));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/overflow_safe_accumulator.md
OVERFLOW_SAFE_ACCUMULATOR -- requirements
Module: overflow_safe_accumulator

Interface
REQ-001 Parameter DATA_W, default 4: operand width in bits.
REQ-002 Parameter ACC_W, default 8: accumulator and result width; SHALL be >= DATA_W.
REQ-003 Parameter CNT_W, default 4: beat-counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operand beat valid.
REQ-007 in_ready  out  1  block accepts an operand beat.
REQ-008 in_data  in  DATA_W  unsigned operand.
REQ-009 in_last  in  1  marks the final beat of a packet; qualified by in_valid.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 out_sum  out  ACC_W  accumulated packet sum.
REQ-013 out_count  out  CNT_W  beats accepted in the packet.
REQ-014 out_ovf  out  1  sticky overflow flag for the packet.
REQ-015 state_out  out  2  current FSM state code.

Function
REQ-016 FSM states SHALL be IDLE=2'b00, ACCUM=2'b01 and HOLD=2'b10; code 2'b11 SHALL transition to IDLE on the next edge, with no other effect.
REQ-017 Every case statement SHALL cover all encodings or carry a default, and every register SHALL be driven from exactly one always block, so that no latch is inferred.
REQ-018 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-019 On an accepted beat in IDLE, the block SHALL set acc to zero-extended in_data, count=1 and ovf=0, then go to HOLD if in_last=1, otherwise to ACCUM.
REQ-020 On an accepted beat in ACCUM, the block SHALL form acc+in_data at ACC_W+1 bits, set ovf on carry-out (sticky), increment count saturating at 2^CNT_W-1, and go to HOLD if in_last=1.
REQ-021 out_valid SHALL be registered and equal 1 exactly while in HOLD; it SHALL rise on the edge that accepts the in_last beat (one-cycle latency).
REQ-022 out_sum, out_count and out_ovf SHALL stay stable while in HOLD, regardless of in_valid.
REQ-023 In HOLD with out_ready=1, the block SHALL return to IDLE on that edge, and out_valid SHALL be 0 from the next cycle.
REQ-024 In IDLE or ACCUM, an edge with in_valid=0 SHALL hold all state.
REQ-025 out_sum, out_count and out_ovf SHALL be driven directly from the acc, count and ovf registers.

Reset
REQ-026 While rst=1, the block SHALL immediately and asynchronously force state=IDLE, acc=0, count=0, ovf=0 and out_valid=0; in_ready then reads 1.
REQ-027 Reset asserted mid-packet (ACCUM or HOLD) SHALL discard the partial packet; the next accepted beat SHALL start a fresh packet.

Configuration
REQ-028 With macro SATURATE_EN defined, an overflowing add SHALL clamp acc to 2^ACC_W-1, and acc SHALL remain there for the rest of the packet.
REQ-029 With SATURATE_EN undefined, acc SHALL wrap modulo 2^ACC_W; out_ovf behaviour SHALL be identical in both builds.

Verification (DATA_W=4, ACC_W=8, CNT_W=4)
REQ-030 Assert rst for 3 cycles, then release -> out_valid=0, out_sum=0, out_count=0, out_ovf=0, state_out=00, in_ready=1.
REQ-031 Send beats 3, 5, 7 (in_last on 7) -> out_valid=1 on the edge accepting 7; out_sum=15, out_count=3, out_ovf=0, state_out=10.
REQ-032 Send 20 beats of 15 with in_last on the 20th -> out_count=15, out_ovf=1; out_sum=255 with SATURATE_EN, 44 without it.
REQ-033 Send a single beat of 9 with in_last, hold out_ready=0 for 5 cycles while driving in_valid=1 -> in_ready=0, out_sum=9 and out_count=1 stable; then out_ready=1 -> IDLE, out_valid=0 next cycle.
REQ-034 Send beats 4 and 6 without in_last, pulse rst, then send 2 with in_last -> out_sum=2, out_count=1, out_ovf=0.
REQ-035 Force the state register to 2'b11 -> state_out=00 after one edge, with acc and count unchanged.
